jzjpcc_hazard_control: RTL and testbench

Pipeline hazard controller for the core: sequences the execute-stage datapath by tracking the destination register of every in-flight instruction in a three-slot scoreboard (EX, MEM, WB). It selects operand forwarding for execute, stalls fetch/decode on load-use hazards, and squashes wrong-path instructions after a taken branch. It sits beside the decode→execute pipeline register and drives that register's hold and bubble controls.

---
 rtl/jzjpcc_hazard_control.sv | 86 ++++++++
 tb/tb_jzjpcc_hazard_control.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jzjpcc_hazard_control.sv
// jzjpcc_hazard_control: EX/MEM/WB destination scoreboard driving forwarding, load-use stalls and branch squashing
module jzjpcc_hazard_control #(
  parameter int BRANCH_PENALTY = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       decode_valid,
  input  logic [4:0] decode_rs1Addr,
  input  logic [4:0] decode_rs2Addr,
  input  logic       decode_usesRs1,
  input  logic       decode_usesRs2,
  input  logic [4:0] decode_rdAddr,
  input  logic       decode_rdWriteEnable,
  input  logic       decode_rdSource,
  input  logic       branchTaken,
  output logic       stallFetch,
  output logic       stallDecode,
  output logic       flushDecode,
  output logic       bubbleExecute,
  output logic [1:0] forwardRs1,
  output logic [1:0] forwardRs2
);
  typedef struct packed {
    logic       valid;
    logic [4:0] rdAddr;
    logic       rdWriteEnable;
    logic       rdSource;
  } slot_t;
  typedef enum logic {IDLE, FLUSH} state_t;
  slot_t      exSlot, memSlot, wbSlot;
  logic [4:0] exRs1Addr, exRs2Addr;
  logic       exUsesRs1, exUsesRs2;
  state_t     state;
  logic [1:0] flushCnt;
  logic       branchStart, branchFlush, loadUse;
  function automatic logic writes(input slot_t s, input logic [4:0] r);
    return s.valid & s.rdWriteEnable & (s.rdAddr == r) & (r != 5'd0);
  endfunction
  // MEM only forwards ALU results; a MEM load can never feed EX because of the load-use bubble
  function automatic logic [1:0] fwd(input logic uses, input logic [4:0] r, input slot_t m, input slot_t w);
    return !uses ? 2'b00 : (writes(m, r) & ~m.rdSource) ? 2'b01 : writes(w, r) ? 2'b10 : 2'b00;
  endfunction
  always_comb begin
    branchStart   = (state == IDLE) & branchTaken & exSlot.valid;
    branchFlush   = branchStart | (state == FLUSH);
    loadUse       = decode_valid & exSlot.rdSource &
                    ((decode_usesRs1 & writes(exSlot, decode_rs1Addr)) |
                     (decode_usesRs2 & writes(exSlot, decode_rs2Addr)));
    bubbleExecute = reset & (branchFlush | loadUse);
    flushDecode   = reset & branchFlush;
    stallFetch    = reset & loadUse & ~branchFlush;
    stallDecode   = stallFetch;
    forwardRs1    = reset ? fwd(exUsesRs1, exRs1Addr, memSlot, wbSlot) : 2'b00;
    forwardRs2    = reset ? fwd(exUsesRs2, exRs2Addr, memSlot, wbSlot) : 2'b00;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      exSlot    <= '0;
      memSlot   <= '0;
      wbSlot    <= '0;
      exRs1Addr <= '0;
      exRs2Addr <= '0;
      exUsesRs1 <= 1'b0;
      exUsesRs2 <= 1'b0;
      state     <= IDLE;
      flushCnt  <= 2'd0;
    end else begin
      wbSlot    <= memSlot;
      memSlot   <= exSlot;
      exSlot    <= '{decode_valid & ~bubbleExecute, decode_rdAddr, decode_rdWriteEnable, decode_rdSource};
      exRs1Addr <= decode_rs1Addr;
      exRs2Addr <= decode_rs2Addr;
      exUsesRs1 <= decode_usesRs1;
      exUsesRs2 <= decode_usesRs2;
      if (state == IDLE) begin
        if (branchStart && BRANCH_PENALTY > 1) begin
          state    <= FLUSH;
          flushCnt <= 2'(BRANCH_PENALTY - 1);
        end
      end else begin
        flushCnt <= flushCnt - 2'd1;
        state    <= (flushCnt == 2'd1) ? IDLE : FLUSH;
      end
    end
  end
endmodule

// File: tb/tb_jzjpcc_hazard_control.sv
// tb_jzjpcc_hazard_control: directed checks of forwarding, load-use stall and branch squash for penalties 1..3
module tb_jzjpcc_hazard_control;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic decode_valid = 1'b0, decode_usesRs1 = 1'b0, decode_usesRs2 = 1'b0;
  logic decode_rdWriteEnable = 1'b0, decode_rdSource = 1'b0, branchTaken = 1'b0;
  logic [4:0] decode_rs1Addr = '0, decode_rs2Addr = '0, decode_rdAddr = '0;
  logic sf2, sd2, fl2, bu2, sf1, sd1, fl1, bu1, sf3, sd3, fl3, bu3;
  logic [1:0] a2, b2, a1, b1, a3, b3;
  logic [7:0] outs, outs1, outs3;
  int total = 0;
  int bad = 0;
  assign outs  = {sf2, sd2, fl2, bu2, a2, b2};
  assign outs1 = {sf1, sd1, fl1, bu1, a1, b1};
  assign outs3 = {sf3, sd3, fl3, bu3, a3, b3};
  always #5 clk = ~clk;
  jzjpcc_hazard_control #(.BRANCH_PENALTY(2)) dut (
    .clock(clk), .reset(reset), .decode_valid(decode_valid),
    .decode_rs1Addr(decode_rs1Addr), .decode_rs2Addr(decode_rs2Addr),
    .decode_usesRs1(decode_usesRs1), .decode_usesRs2(decode_usesRs2),
    .decode_rdAddr(decode_rdAddr), .decode_rdWriteEnable(decode_rdWriteEnable),
    .decode_rdSource(decode_rdSource), .branchTaken(branchTaken),
    .stallFetch(sf2), .stallDecode(sd2), .flushDecode(fl2), .bubbleExecute(bu2),
    .forwardRs1(a2), .forwardRs2(b2));
  jzjpcc_hazard_control #(.BRANCH_PENALTY(1)) dut1 (
    .clock(clk), .reset(reset), .decode_valid(decode_valid),
    .decode_rs1Addr(decode_rs1Addr), .decode_rs2Addr(decode_rs2Addr),
    .decode_usesRs1(decode_usesRs1), .decode_usesRs2(decode_usesRs2),
    .decode_rdAddr(decode_rdAddr), .decode_rdWriteEnable(decode_rdWriteEnable),
    .decode_rdSource(decode_rdSource), .branchTaken(branchTaken),
    .stallFetch(sf1), .stallDecode(sd1), .flushDecode(fl1), .bubbleExecute(bu1),
    .forwardRs1(a1), .forwardRs2(b1));
  jzjpcc_hazard_control #(.BRANCH_PENALTY(3)) dut3 (
    .clock(clk), .reset(reset), .decode_valid(decode_valid),
    .decode_rs1Addr(decode_rs1Addr), .decode_rs2Addr(decode_rs2Addr),
    .decode_usesRs1(decode_usesRs1), .decode_usesRs2(decode_usesRs2),
    .decode_rdAddr(decode_rdAddr), .decode_rdWriteEnable(decode_rdWriteEnable),
    .decode_rdSource(decode_rdSource), .branchTaken(branchTaken),
    .stallFetch(sf3), .stallDecode(sd3), .flushDecode(fl3), .bubbleExecute(bu3),
    .forwardRs1(a3), .forwardRs2(b3));
  // a valid EX operand must never find its producer as a load still in MEM
  always @(negedge clk) begin
    if (reset && dut.exSlot.valid && dut.memSlot.valid && dut.memSlot.rdWriteEnable &&
        dut.memSlot.rdSource && dut.memSlot.rdAddr != 5'd0 &&
        ((dut.exUsesRs1 && dut.exRs1Addr == dut.memSlot.rdAddr) ||
         (dut.exUsesRs2 && dut.exRs2Addr == dut.memSlot.rdAddr))) begin
      bad++;
      $display("FAIL mem_load_feeds_ex: got load x%0d in MEM feeding EX, want none", dut.memSlot.rdAddr);
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic dec(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                     input logic u2, input logic [4:0] rd, input logic we, input logic src);
    decode_valid = v;
    decode_rs1Addr = rs1;
    decode_usesRs1 = u1;
    decode_rs2Addr = rs2;
    decode_usesRs2 = u2;
    decode_rdAddr = rd;
    decode_rdWriteEnable = we;
    decode_rdSource = src;
  endtask
  task automatic idle(input int n);
    dec(0, 0, 0, 0, 0, 0, 0, 0);
    branchTaken = 1'b0;
    repeat (n) tick();
  endtask
  task automatic test_reset;
    reset = 1'b0;
    branchTaken = 1'b1;
    dec(1, 5, 1, 5, 1, 5, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({outs, outs1, outs3} !== 24'h0) begin
        bad++;
        $display("FAIL reset_hold c%0d: got %h want 000000", i, {outs, outs1, outs3});
      end
      tick();
    end
    reset = 1'b1;
    dec(1, 5, 1, 0, 0, 6, 1, 0);
    #1;
    total++;
    if ({outs, outs1, outs3} !== 24'h0) begin
      bad++;
      $display("FAIL reset_release_branch_ignored: got %h want 000000", {outs, outs1, outs3});
    end
    tick();
    idle(0);
    #1;
    total++;
    if (outs !== 8'h00) begin
      bad++;
      $display("FAIL reset_empty_scoreboard: got %b want 00000000", outs);
    end
    idle(2);
  endtask
  task automatic test_alu_chain;
    dec(1, 0, 0, 0, 0, 5, 1, 0);
    tick();
    dec(1, 5, 1, 0, 0, 6, 1, 0);
    #1;
    total++;
    if (outs !== 8'h00) begin
      bad++;
      $display("FAIL alu_no_stall: got %b want 00000000", outs);
    end
    tick();
    idle(0);
    #1;
    total++;
    if (outs !== 8'b0000_01_00) begin
      bad++;
      $display("FAIL alu_fwd_mem: got %b want 00000100", outs);
    end
    idle(2);
    dec(1, 0, 0, 0, 0, 5, 1, 0);
    tick();
    dec(1, 1, 1, 2, 1, 9, 1, 0);
    tick();
    dec(1, 5, 1, 9, 1, 10, 1, 0);
    tick();
    idle(0);
    #1;
    total++;
    if (outs !== 8'b0000_10_01) begin
      bad++;
      $display("FAIL alu_fwd_wb_gap: got %b want 00001001", outs);
    end
    idle(2);
    dec(1, 0, 0, 0, 0, 5, 1, 0);
    tick();
    dec(1, 0, 0, 0, 0, 5, 1, 0);
    tick();
    dec(1, 5, 1, 5, 1, 11, 1, 0);
    tick();
    idle(0);
    #1;
    total++;
    if (outs !== 8'b0000_01_01) begin
      bad++;
      $display("FAIL alu_youngest_wins: got %b want 00000101", outs);
    end
    idle(2);
    dec(1, 0, 0, 0, 0, 0, 1, 0);
    tick();
    dec(1, 0, 1, 0, 1, 12, 1, 0);
    tick();
    idle(0);
    #1;
    total++;
    if (outs !== 8'h00) begin
      bad++;
      $display("FAIL alu_x0_no_fwd: got %b want 00000000", outs);
    end
    idle(2);
    dec(1, 0, 0, 0, 0, 5, 1, 0);
    tick();
    dec(1, 5, 0, 0, 0, 12, 1, 0);
    tick();
    idle(0);
    #1;
    total++;
    if (outs !== 8'h00) begin
      bad++;
      $display("FAIL alu_unused_operand: got %b want 00000000", outs);
    end
    idle(2);
  endtask
  task automatic test_load_use;
    dec(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    dec(1, 3, 1, 7, 1, 11, 1, 0);
    #1;
    total++;
    if (outs !== 8'b1101_00_00) begin
      bad++;
      $display("FAIL load_use_stall: got %b want 11010000", outs);
    end
    tick();
    #1;
    total++;
    if (outs[7:4] !== 4'b0000) begin
      bad++;
      $display("FAIL load_use_single_bubble: got %b want 0000", outs[7:4]);
    end
    tick();
    idle(0);
    #1;
    total++;
    if (outs !== 8'b0000_00_10) begin
      bad++;
      $display("FAIL load_use_fwd_wb: got %b want 00000010", outs);
    end
    idle(2);
    dec(1, 0, 0, 0, 0, 0, 1, 1);
    tick();
    dec(1, 0, 1, 0, 1, 12, 1, 0);
    #1;
    total++;
    if (outs !== 8'h00) begin
      bad++;
      $display("FAIL load_x0_no_stall: got %b want 00000000", outs);
    end
    idle(2);
    dec(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    dec(1, 0, 0, 7, 0, 12, 1, 0);
    #1;
    total++;
    if (outs !== 8'h00) begin
      bad++;
      $display("FAIL load_unused_no_stall: got %b want 00000000", outs);
    end
    idle(2);
  endtask
  task automatic test_branch;
    logic [3:0] e2 [4];
    logic [3:0] e1 [4];
    logic [3:0] e3 [4];
    e2 = '{4'b0011, 4'b0011, 4'b0000, 4'b0000};
    e1 = '{4'b0011, 4'b0000, 4'b0000, 4'b0000};
    e3 = '{4'b0011, 4'b0011, 4'b0011, 4'b0000};
    dec(1, 0, 0, 0, 0, 8, 1, 0);
    tick();
    dec(1, 0, 0, 0, 0, 0, 0, 0);
    branchTaken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if ({outs[7:4], outs1[7:4], outs3[7:4]} !== {e2[i], e1[i], e3[i]}) begin
        bad++;
        $display("FAIL branch_penalty c%0d: got p2=%b p1=%b p3=%b want p2=%b p1=%b p3=%b",
                 i, outs[7:4], outs1[7:4], outs3[7:4], e2[i], e1[i], e3[i]);
      end
      tick();
      branchTaken = 1'b0;
    end
    idle(2);
  endtask
  task automatic test_conflict;
    dec(1, 0, 0, 0, 0, 7, 1, 1);
    tick();
    dec(1, 7, 1, 0, 0, 13, 1, 0);
    branchTaken = 1'b1;
    #1;
    total++;
    if (outs !== 8'b0011_00_00) begin
      bad++;
      $display("FAIL conflict_branch_wins: got %b want 00110000", outs);
    end
    tick();
    branchTaken = 1'b0;
    #1;
    total++;
    if (outs[7:4] !== 4'b0011) begin
      bad++;
      $display("FAIL conflict_flush_continues: got %b want 0011", outs[7:4]);
    end
    tick();
    #1;
    total++;
    if (outs[7:4] !== 4'b0000) begin
      bad++;
      $display("FAIL conflict_flush_done: got %b want 0000", outs[7:4]);
    end
    idle(2);
  endtask
  task automatic test_reset_abort;
    dec(1, 0, 0, 0, 0, 5, 1, 0);
    tick();
    dec(1, 0, 0, 0, 0, 0, 0, 0);
    branchTaken = 1'b1;
    #1;
    total++;
    if (outs3[7:4] !== 4'b0011) begin
      bad++;
      $display("FAIL abort_flush_start: got %b want 0011", outs3[7:4]);
    end
    tick();
    branchTaken = 1'b0;
    reset = 1'b0;
    dec(1, 0, 0, 0, 0, 5, 1, 0);
    #1;
    total++;
    if ({outs, outs1, outs3} !== 24'h0) begin
      bad++;
      $display("FAIL abort_reset_forces_zero: got %h want 000000", {outs, outs1, outs3});
    end
    tick();
    reset = 1'b1;
    dec(1, 5, 1, 0, 0, 14, 1, 0);
    #1;
    total++;
    if ({outs, outs1, outs3} !== 24'h0) begin
      bad++;
      $display("FAIL abort_flush_terminated: got %h want 000000", {outs, outs1, outs3});
    end
    tick();
    idle(0);
    #1;
    total++;
    if ({outs, outs3} !== 16'h0) begin
      bad++;
      $display("FAIL abort_scoreboard_empty: got %h want 0000", {outs, outs3});
    end
    idle(2);
  endtask
  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_branch();
    test_conflict();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
